// File: rtl/and_rsp_checker.sv
// Response checker for the AND-gate stimulus interface: captures A&B while running,
// delays it by the DUT latency, compares against Y and reports pass/fail statistics.
module and_rsp_checker #(
  parameter int LATENCY  = 0,
  parameter int NUM_STIM = 100,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_STIM - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(LATENCY - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [2:0]       drain_cnt_r;
  logic             cap_s;
  logic             start_s;
  logic             cmp_vld_s;
  logic             cmp_exp_s;
  logic [CNT_W-1:0] cmp_idx_s;
  logic             match_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign cap_s   = (state_r == CAPTURE);
  assign start_s = ((state_r == IDLE) || (state_r == DONE)) && en;
  // 4-state compare so an X or Z on Y never counts as a match
  assign match_s = (Y === cmp_exp_s);

  if (LATENCY > 0) begin : g_pipe
    logic [LATENCY-1:0] pipe_vld_r;
    logic [LATENCY-1:0] pipe_exp_r;
    logic [CNT_W-1:0]   pipe_idx_r [LATENCY];

    // Expected-value delay line; bubbles enter whenever we are not capturing
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_vld_r <= '0;
        pipe_exp_r <= '0;
        for (int i = 0; i < LATENCY; i++) pipe_idx_r[i] <= '0;
      end else begin
        pipe_vld_r[0] <= cap_s;
        pipe_exp_r[0] <= A & B;
        pipe_idx_r[0] <= sample_cnt;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_vld_r[i] <= pipe_vld_r[i-1];
          pipe_exp_r[i] <= pipe_exp_r[i-1];
          pipe_idx_r[i] <= pipe_idx_r[i-1];
        end
      end
    end

    assign cmp_vld_s = pipe_vld_r[LATENCY-1];
    assign cmp_exp_s = pipe_exp_r[LATENCY-1];
    assign cmp_idx_s = pipe_idx_r[LATENCY-1];
  end else begin : g_comb
    assign cmp_vld_s = cap_s;
    assign cmp_exp_s = A & B;
    assign cmp_idx_s = sample_cnt;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (en) state_s = CAPTURE;
        else    state_s = state_r;
      end
      CAPTURE: begin
        if (sample_cnt == LAST_IDX) state_s = (LATENCY > 0) ? DRAIN : DONE;
        else                        state_s = CAPTURE;
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_s = DONE;
        else                           state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, status flags and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      drain_cnt_r   <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      sample_cnt    <= '0;
      first_err_idx <= '0;
    end else begin
      state_r     <= state_s;
      busy        <= (state_s == CAPTURE) || (state_s == DRAIN);
      done        <= (state_s == DONE);
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 3'd1 : 3'd0;
      if (start_s) begin
        err           <= 1'b0;
        pass_cnt      <= '0;
        fail_cnt      <= '0;
        sample_cnt    <= '0;
        first_err_idx <= '0;
      end else begin
        if (cap_s) sample_cnt <= sat_inc(sample_cnt);
        if (cmp_vld_s) begin
          if (match_s) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt <= sat_inc(fail_cnt);
            if (!err) begin
              err           <= 1'b1;
              first_err_idx <= cmp_idx_s;
            end
          end
        end
      end
    end
  end

endmodule
